gdp_fp16_accum: RTL
===================

Name: gdp_fp16_accum

Overview:
- Downstream of the group dot-product (GDP) stage in the GEMM datapath.
- Accepts one GDP result per group: a signed integer mantissa sum and an unbiased-sum exponent.
- Aligns and accumulates GROUPS_PER_NV groups to form one native-vector (NV) dot product.
- Normalizes and rounds the NV sum to IEEE FP16, then presents it on a valid/ready output toward the result/BRAM writer.

Parameters:
- GDP_MANT_W, 21: signed GDP mantissa sum width (32 products of 8-bit signed mantissas).
- GDP_EXP_W, 9: GDP exponent width; the sum of two 8-bit shared exponents.
- GROUPS_PER_NV, 4: groups per NV; equals NV_WIDTH/GROUP_SIZE.
- ACC_W, 24: signed accumulator width.
- EXP_OFFSET, 266: value = mant * 2^(exp - EXP_OFFSET); 266 = 2*127 + 2*6 fraction bits.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_grp_valid  in  1  GDP result valid
- o_grp_ready  out  1  block accepts a GDP result
- i_grp_mant  in  GDP_MANT_W  signed two's-complement group sum
- i_grp_exp  in  GDP_EXP_W  unsigned group exponent
- o_fp16_valid  out  1  FP16 result valid
- i_fp16_ready  in  1  consumer accepts the result
- o_fp16  out  16  FP16 NV result
- o_busy  out  1  high when any group is accepted or a result is pending

Behaviour:
- Clocking and reset: one clock, i_clk; reset is synchronous and active-high on i_reset.
- While i_reset is high, all outputs are 0: o_grp_ready=0, o_fp16_valid=0, o_fp16=16'h0000, o_busy=0.
- The group counter and accumulator clear under reset. Reset mid-accumulation or mid-output discards all partial state.
- FSM states: ACCUM, NORM, ROUND, OUT. The state after reset is ACCUM.
- ACCUM: o_grp_ready=1. A group is accepted when i_grp_valid and o_grp_ready are both high.
  - First group: load acc_m = sign-extended mant, acc_e = exp.
  - Later groups: the operand with the smaller exponent is arithmetically right-shifted by the exponent difference (truncate, no sticky). The larger exponent is kept.
  - If the shift is >= ACC_W, the shifted operand is treated as 0.
  - Equal exponents: add directly.
  - grp_cnt increments on each accept. When the accept with grp_cnt == GROUPS_PER_NV-1 occurs, go to NORM and reset grp_cnt to 0.
- NORM (1 cycle), o_grp_ready=0:
  - sign = acc_m MSB; mag = |acc_m|.
  - p = index of the leading one of mag.
  - E = p + acc_e - EXP_OFFSET + 15, computed signed with at least 11 bits.
  - Left-align mag so the bits below the leading one form the fraction.
- ROUND (1 cycle): round to nearest even on a 10-bit fraction, using the guard bit plus the OR of all lower bits as sticky.
  - A fraction carry-out increments E and zeroes the fraction.
  - mag == 0 gives +0 (16'h0000), including when cancellation yields zero.
  - E >= 31 after rounding gives signed infinity (7C00/FC00).
  - E <= 0 gives signed zero; subnormals are flushed.
  - o_fp16 is registered; go to OUT.
- OUT: o_fp16_valid=1 and o_fp16 holds stable until i_fp16_ready is high. On the handshake, return to ACCUM.
  - o_grp_ready=1 from the next cycle, so NVs can stream back to back.
- Latency: o_fp16_valid rises 3 cycles after the last group's accept edge.
- Throughput: one NV per GROUPS_PER_NV+3 cycles with i_fp16_ready held at 1.
- i_grp_valid while o_grp_ready=0 is held off by the producer and is not an error.

Decomposition:
- Add to gemm_pkg:
  - GROUPS_PER_NV = NV_WIDTH/GROUP_SIZE
  - GDP_MANT_WIDTH = 21
  - GDP_EXP_WIDTH = 9
  - GFP8_EXP_BIAS = 127
  - GFP8_FRAC_BITS = 6
  - FP16 constants: FP16_POS_INF = 16'h7C00, FP16_NEG_INF = 16'hFC00, FP16_EXP_MAX = 31
  - FSM state enum typedef
- Sub-module fp16_norm_round: leading-one detect, shift, round-to-nearest-even and saturation, split across the NORM and ROUND registers. It is reusable by the output converter.

Test Plan:
- Four groups, each mant=4096, exp=254 (1.0 each) -> o_fp16=16'h4400 (4.0), o_fp16_valid 3 cycles after the 4th accept.
- Groups (4096,254), (4096,256), (0,254), (0,254) -> 1.0+4.0 -> 16'h4500. Groups (-4096,254) then three zeros -> 16'hBC00.
- Rounding, other groups 0 at exp 254:
  - (4098,254), a tie with even LSB -> 16'h3C00.
  - (4102,254), a tie with odd LSB -> 16'h3C02.
  - Cancellation (+4096,254), (-4096,254) -> 16'h0000.
- Overflow and underflow:
  - Four groups of (262144,262) -> E=31 -> 16'h7C00.
  - One group (1,240), others 0 -> E<=0 -> 16'h0000.
- Backpressure: hold i_fp16_ready=0 for 5 cycles in OUT -> o_fp16 stable, o_grp_ready=0, o_busy=1. Release -> one handshake, then o_grp_ready=1 next cycle. Back-to-back NVs produce 2 distinct results in order.
- Reset: assert i_reset for 1 cycle after 2 groups accepted -> all outputs 0. The next 4 groups of (4096,254) -> 16'h4400, with no residue from the aborted NV.

Source files
------------

// File: rtl/gdp_fp16_accum_pkg.sv
// Shared constants and FSM state type for the GDP-to-FP16 accumulator.
package gdp_fp16_accum_pkg;

  // GEMM geometry: a native vector is split into groups of GROUP_SIZE lanes.
  localparam int NV_WIDTH       = 128;
  localparam int GROUP_SIZE     = 32;
  localparam int GROUPS_PER_NV  = NV_WIDTH / GROUP_SIZE;

  // Group dot-product result format.
  localparam int GDP_MANT_WIDTH = 21;
  localparam int GDP_EXP_WIDTH  = 9;
  localparam int ACC_WIDTH      = 24;

  // GFP8 operand format: value = mant * 2^(exp - bias - frac_bits) per operand,
  // so a product carries twice the bias and twice the fraction bits.
  localparam int GFP8_EXP_BIAS  = 127;
  localparam int GFP8_FRAC_BITS = 6;
  localparam int GDP_EXP_OFFSET = 2 * GFP8_EXP_BIAS + 2 * GFP8_FRAC_BITS;

  // IEEE half precision.
  localparam logic [15:0] FP16_POS_INF   = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF   = 16'hFC00;
  localparam int          FP16_EXP_MAX   = 31;
  localparam int          FP16_EXP_BIAS  = 15;
  localparam int          FP16_FRAC_BITS = 10;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/gdp_fp16_accum_norm_round.sv
// Two-register normalize / round-to-nearest-even stage turning a signed
// fixed-point accumulator into FP16. Reusable by any converter that can
// pulse norm_en then round_en on consecutive cycles.
module gdp_fp16_accum_norm_round
  import gdp_fp16_accum_pkg::*;
#(
  parameter int ACC_W      = ACC_WIDTH,
  parameter int EXP_W      = GDP_EXP_WIDTH,
  parameter int EXP_OFFSET = GDP_EXP_OFFSET
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             norm_en,
  input  logic             round_en,
  input  logic [ACC_W-1:0] acc_m,
  input  logic [EXP_W-1:0] acc_e,
  output logic [15:0]      fp16
);

  localparam int LEAD_W = $clog2(ACC_W);
  localparam int FB     = FP16_FRAC_BITS;
  localparam int GRD    = ACC_W - 2 - FB;   // first bit below the kept fraction

  logic [ACC_W-1:0]  mag_c;
  logic [ACC_W-1:0]  aligned_c;
  logic [ACC_W-1:0]  aligned_reg;
  logic [LEAD_W-1:0] lead_c;
  logic signed [11:0] exp_c;
  logic signed [11:0] exp_reg;
  logic signed [11:0] exp_r;
  logic              sign_reg;
  logic [FB-1:0]     frac;
  logic [FB-1:0]     frac_r;
  logic [FB:0]       frac_sum;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [15:0]       fp16_c;
  logic [15:0]       fp16_reg;

  // Magnitude, leading-one position, left alignment and unbiased FP16 exponent.
  always_comb begin
    mag_c  = acc_m[ACC_W-1] ? (~acc_m + ACC_W'(1)) : acc_m;
    lead_c = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag_c[i]) lead_c = LEAD_W'(i);
    end
    aligned_c = mag_c << (LEAD_W'(ACC_W - 1) - lead_c);
    exp_c     = 12'(lead_c) + 12'(acc_e) - 12'(EXP_OFFSET) + 12'(FP16_EXP_BIAS);
  end

  // NORM register: the aligned MSB doubles as the non-zero flag.
  always_ff @(posedge clk) begin
    if (srst) begin
      sign_reg    <= 1'b0;
      exp_reg     <= '0;
      aligned_reg <= '0;
    end else if (norm_en) begin
      sign_reg    <= acc_m[ACC_W-1];
      exp_reg     <= exp_c;
      aligned_reg <= aligned_c;
    end
  end

  // Round to nearest even, then saturate to infinity or flush to zero.
  always_comb begin
    frac     = aligned_reg[ACC_W-2 -: FB];
    guard    = aligned_reg[GRD];
    sticky   = |aligned_reg[GRD-1:0];
    round_up = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + (FB + 1)'(round_up);
    if (frac_sum[FB]) begin
      exp_r  = exp_reg + 12'sd1;
      frac_r = '0;
    end else begin
      exp_r  = exp_reg;
      frac_r = frac_sum[FB-1:0];
    end
    fp16_c = {sign_reg, exp_r[4:0], frac_r};
    if (!aligned_reg[ACC_W-1]) begin
      fp16_c = 16'h0000;
    end else if (exp_r >= 12'(FP16_EXP_MAX)) begin
      fp16_c = sign_reg ? FP16_NEG_INF : FP16_POS_INF;
    end else if (exp_r <= 12'sd0) begin
      fp16_c = {sign_reg, 15'b0};
    end
  end

  // ROUND register: holds the finished FP16 word until the next NV.
  always_ff @(posedge clk) begin
    if (srst) begin
      fp16_reg <= '0;
    end else if (round_en) begin
      fp16_reg <= fp16_c;
    end
  end

  assign fp16 = fp16_reg;

endmodule

// File: rtl/gdp_fp16_accum.sv
// Accumulates GROUPS_PER_NV group dot-product results (aligned by exponent)
// into one native-vector sum and emits it as FP16 on a valid/ready port.
module gdp_fp16_accum #(
  parameter int GDP_MANT_W    = gdp_fp16_accum_pkg::GDP_MANT_WIDTH,
  parameter int GDP_EXP_W     = gdp_fp16_accum_pkg::GDP_EXP_WIDTH,
  parameter int GROUPS_PER_NV = gdp_fp16_accum_pkg::GROUPS_PER_NV,
  parameter int ACC_W         = gdp_fp16_accum_pkg::ACC_WIDTH,
  parameter int EXP_OFFSET    = gdp_fp16_accum_pkg::GDP_EXP_OFFSET
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_grp_valid,
  output logic                  o_grp_ready,
  input  logic [GDP_MANT_W-1:0] i_grp_mant,
  input  logic [GDP_EXP_W-1:0]  i_grp_exp,
  output logic                  o_fp16_valid,
  input  logic                  i_fp16_ready,
  output logic [15:0]           o_fp16,
  output logic                  o_busy
);

  import gdp_fp16_accum_pkg::*;

  localparam int CNT_W = (GROUPS_PER_NV > 1) ? $clog2(GROUPS_PER_NV) : 1;
  localparam logic [GDP_EXP_W-1:0] SHIFT_LIMIT = GDP_EXP_W'(ACC_W);

  state_t state_reg, state_next;
  logic [CNT_W-1:0]       grp_cnt_reg;
  logic signed [ACC_W-1:0] acc_m_reg;
  logic [GDP_EXP_W-1:0]   acc_e_reg;
  logic signed [ACC_W-1:0] mant_ext;
  logic signed [ACC_W-1:0] shift_src;
  logic signed [ACC_W-1:0] keep_op;
  logic signed [ACC_W-1:0] shifted_op;
  logic signed [ACC_W-1:0] sum_c;
  logic [GDP_EXP_W-1:0]   diff;
  logic [GDP_EXP_W-1:0]   big_e;
  logic                   accept;
  logic                   last_grp;
  logic                   norm_en;
  logic                   round_en;
  logic [15:0]            fp16;

  assign accept   = i_grp_valid && (state_reg == ST_ACCUM);
  assign last_grp = (grp_cnt_reg == CNT_W'(GROUPS_PER_NV - 1));

  // Exponent alignment: the smaller-exponent operand is shifted right and
  // truncated; shifts past the accumulator width contribute nothing.
  always_comb begin
    mant_ext = {{(ACC_W - GDP_MANT_W){i_grp_mant[GDP_MANT_W-1]}}, i_grp_mant};
    if (i_grp_exp >= acc_e_reg) begin
      big_e     = i_grp_exp;
      diff      = i_grp_exp - acc_e_reg;
      shift_src = acc_m_reg;
      keep_op   = mant_ext;
    end else begin
      big_e     = acc_e_reg;
      diff      = acc_e_reg - i_grp_exp;
      shift_src = mant_ext;
      keep_op   = acc_m_reg;
    end
    shifted_op = (diff >= SHIFT_LIMIT) ? '0 : (shift_src >>> diff);
    sum_c      = keep_op + shifted_op;
  end

  // Group counter and accumulator; the first group of an NV loads directly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      grp_cnt_reg <= '0;
      acc_m_reg   <= '0;
      acc_e_reg   <= '0;
    end else if (accept) begin
      grp_cnt_reg <= last_grp ? '0 : grp_cnt_reg + CNT_W'(1);
      if (grp_cnt_reg == '0) begin
        acc_m_reg <= mant_ext;
        acc_e_reg <= i_grp_exp;
      end else begin
        acc_m_reg <= sum_c;
        acc_e_reg <= big_e;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state and stage enables for the normalize/round pipeline.
  always_comb begin
    state_next = state_reg;
    norm_en    = 1'b0;
    round_en   = 1'b0;
    case (state_reg)
      ST_ACCUM: if (accept && last_grp) state_next = ST_NORM;
      ST_NORM: begin
        norm_en    = 1'b1;
        state_next = ST_ROUND;
      end
      ST_ROUND: begin
        round_en   = 1'b1;
        state_next = ST_OUT;
      end
      ST_OUT: if (i_fp16_ready) state_next = ST_ACCUM;
      default: state_next = ST_ACCUM;
    endcase
  end

  gdp_fp16_accum_norm_round #(
    .ACC_W      (ACC_W),
    .EXP_W      (GDP_EXP_W),
    .EXP_OFFSET (EXP_OFFSET)
  ) u_norm_round (
    .clk      (i_clk),
    .srst     (i_reset),
    .norm_en  (norm_en),
    .round_en (round_en),
    .acc_m    (acc_m_reg),
    .acc_e    (acc_e_reg),
    .fp16     (fp16)
  );

  // All outputs are forced low while reset is held.
  assign o_grp_ready  = !i_reset && (state_reg == ST_ACCUM);
  assign o_fp16_valid = !i_reset && (state_reg == ST_OUT);
  assign o_fp16       = i_reset ? 16'h0000 : fp16;
  assign o_busy       = !i_reset && ((state_reg != ST_ACCUM) || (grp_cnt_reg != '0));

endmodule
